// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline: the ID-stage decoder produces these
// codes and the ID/EX boundary consumes them.
package mips_pipe_pkg;

    // Destination register select
    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10
    } regDst_e;

    // Conditional branch kind resolved in EX
    typedef enum logic [1:0] {
        BRANCH_NONE = 2'b00,
        BRANCH_BEQ  = 2'b01,
        BRANCH_BNE  = 2'b11
    } branch_e;

    // ALU operation codes; ALUOP_RTYPE defers to the funct field in EX
    typedef enum logic [3:0] {
        ALUOP_ADD   = 4'h0,
        ALUOP_SUB   = 4'h1,
        ALUOP_AND   = 4'h2,
        ALUOP_OR    = 4'h3,
        ALUOP_XOR   = 4'h4,
        ALUOP_SLT   = 4'h5,
        ALUOP_LUI   = 4'h6,
        ALUOP_RTYPE = 4'hF
    } aluOp_e;

    // Primary opcodes
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    // R-type function codes
    typedef enum logic [5:0] {
        FN_JR  = 6'h08,
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25
    } funct_e;

    // True when the instruction reads rt as a source operand (R-type, store, branch)
    function automatic logic usesRt(input logic [1:0] regDst,
                                    input logic       memWrite,
                                    input logic [1:0] branch);
        return (regDst == REGDST_RD) | memWrite | (branch != BRANCH_NONE);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the
// instruction in ID forces a one-cycle stall. A flush suppresses the stall
// because the ID instruction is being discarded anyway.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic [REG_W-1:0] Rt_EX,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             Flush_EX,
    output logic             Stall
);

    logic rsMatch;
    logic rtMatch;

    // Register $zero never carries a dependency
    always_comb begin
        rsMatch = (Rt_EX == Rs_ID);
        rtMatch = UsesRt_ID & (Rt_EX == Rt_ID);
        Stall   = ~Flush_EX & MemRead_EX & RegWrite_EX & (Rt_EX != '0) & (rsMatch | rtMatch);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decoded control and operands, extends the
// immediate, turns flushed or stalled slots into bubbles, records the first
// illegal instruction and counts stall cycles.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        RegDst_ID,
    input  logic              MemToReg_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic              MemWrite_ID,
    input  logic              Jump_ID,
    input  logic              Jal_ID,
    input  logic              Jr_ID,
    input  logic              SignExtend_ID,
    input  logic              OpInstError_ID,
    input  logic [1:0]        Branch_ID,
    input  logic [3:0]        ALUOp_ID,
    input  logic [DATA_W-1:0] PCPlus4_ID,
    input  logic [DATA_W-1:0] RsData_ID,
    input  logic [DATA_W-1:0] RtData_ID,
    input  logic [15:0]       Imm_ID,
    input  logic [REG_W-1:0]  Rs_ID,
    input  logic [REG_W-1:0]  Rt_ID,
    input  logic [REG_W-1:0]  Rd_ID,
    input  logic [REG_W-1:0]  Shamt_ID,
    input  logic              Flush_EX,
    output logic [1:0]        RegDst_EX,
    output logic              MemToReg_EX,
    output logic              RegWrite_EX,
    output logic              MemRead_EX,
    output logic              MemWrite_EX,
    output logic              Jump_EX,
    output logic              Jal_EX,
    output logic              Jr_EX,
    output logic [1:0]        Branch_EX,
    output logic [3:0]        ALUOp_EX,
    output logic [DATA_W-1:0] PCPlus4_EX,
    output logic [DATA_W-1:0] RsData_EX,
    output logic [DATA_W-1:0] RtData_EX,
    output logic [REG_W-1:0]  Rs_EX,
    output logic [REG_W-1:0]  Rt_EX,
    output logic [REG_W-1:0]  Rd_EX,
    output logic [REG_W-1:0]  Shamt_EX,
    output logic [DATA_W-1:0] ImmExt_EX,
    output logic              Stall,
    output logic              ErrSticky,
    output logic [DATA_W-1:0] ErrPC,
    output logic [CNT_W-1:0]  StallCount
);

    logic              usesRtId;
    logic              bubble;
    logic [DATA_W-1:0] immExt;

    assign usesRtId = usesRt(RegDst_ID, MemWrite_ID, Branch_ID);

    hazard_detect #(
        .REG_W(REG_W)
    ) uHazardDetect (
        .MemRead_EX (MemRead_EX),
        .RegWrite_EX(RegWrite_EX),
        .Rt_EX      (Rt_EX),
        .Rs_ID      (Rs_ID),
        .Rt_ID      (Rt_ID),
        .UsesRt_ID  (usesRtId),
        .Flush_EX   (Flush_EX),
        .Stall      (Stall)
    );

    // A flushed or stalled slot enters EX with all side-effecting controls cleared
    assign bubble = Flush_EX | Stall;

    // Immediate extension: upper bits replicate the sign bit only when asked to
    assign immExt[15:0] = Imm_ID;
    generate
        for (genvar gi = 16; gi < DATA_W; gi++) begin : genImmExt
            assign immExt[gi] = SignExtend_ID & Imm_ID[15];
        end
    endgenerate

    // Control registers: cleared on reset and on bubbles
    always_ff @(posedge CLK) begin
        if (Reset || bubble) begin
            RegDst_EX   <= '0;
            MemToReg_EX <= 1'b0;
            RegWrite_EX <= 1'b0;
            MemRead_EX  <= 1'b0;
            MemWrite_EX <= 1'b0;
            Jump_EX     <= 1'b0;
            Jal_EX      <= 1'b0;
            Jr_EX       <= 1'b0;
            Branch_EX   <= '0;
            ALUOp_EX    <= '0;
        end else begin
            RegDst_EX   <= RegDst_ID;
            MemToReg_EX <= MemToReg_ID;
            RegWrite_EX <= RegWrite_ID;
            MemRead_EX  <= MemRead_ID;
            MemWrite_EX <= MemWrite_ID;
            Jump_EX     <= Jump_ID;
            Jal_EX      <= Jal_ID;
            Jr_EX       <= Jr_ID;
            Branch_EX   <= Branch_ID;
            ALUOp_EX    <= ALUOp_ID;
        end
    end

    // Data and specifier registers load every cycle; in a bubble they are inert
    always_ff @(posedge CLK) begin
        if (Reset) begin
            PCPlus4_EX <= '0;
            RsData_EX  <= '0;
            RtData_EX  <= '0;
            Rs_EX      <= '0;
            Rt_EX      <= '0;
            Rd_EX      <= '0;
            Shamt_EX   <= '0;
            ImmExt_EX  <= '0;
        end else begin
            PCPlus4_EX <= PCPlus4_ID;
            RsData_EX  <= RsData_ID;
            RtData_EX  <= RtData_ID;
            Rs_EX      <= Rs_ID;
            Rt_EX      <= Rt_ID;
            Rd_EX      <= Rd_ID;
            Shamt_EX   <= Shamt_ID;
            ImmExt_EX  <= immExt;
        end
    end

    // Capture the address of the first illegal instruction that genuinely enters EX
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ErrSticky <= 1'b0;
            ErrPC     <= '0;
        end else if (!bubble && OpInstError_ID && !ErrSticky) begin
            ErrSticky <= 1'b1;
            ErrPC     <= PCPlus4_ID - DATA_W'(4);
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != '1)) begin
            StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
